metropolis_exp: RTL and testbench

- Evaluates the Metropolis acceptance test for one replica-exchange / 2-opt candidate move.
- Computes exp(−a) with a 15-term Horner Taylor series, driven cycle-by-cycle by the node controller's exp_init / exp_run / exp_recip / exp_fin sequence.
- Compares the result against a uniform random number and issues the accept decision.
- Sits directly downstream of the node controller, between the distance-delta datapath and the replica/exchange update logic.

---
 rtl/metropolis_exp_if.sv | 39 +++
 rtl/metropolis_exp.sv | 170 +++++++++++++++++
 tb/tb_metropolis_exp.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/metropolis_exp_if.sv
`default_nettype none
// ============================================================================
//  Module      : metropolis_exp_if
//  Description : Handshake/data bundle between the node controller (master)
//                and the Metropolis acceptance evaluator (slave).
//  Ports       : exp_init/exp_run/exp_fin  controller sequence strobes
//                exp_recip [16:0]          Q2.15 series reciprocal 1/n
//                exp_x     [14:0]          Q3.12 exponent magnitude a
//                exp_neg                   delta <= 0, accept unconditionally
//                rand_i    [15:0]          Q0.16 uniform random value
//                exp_val   [16:0]          Q1.16 exp(-a) result
//                accept/accept_valid       decision and its one-cycle strobe
//                seq_err                   one-cycle protocol-violation strobe
//  Revision    : 1.0  initial release
// ============================================================================
interface metropolis_exp_if;
    logic        exp_init;
    logic        exp_run;
    logic        exp_fin;
    logic [16:0] exp_recip;
    logic [14:0] exp_x;
    logic        exp_neg;
    logic [15:0] rand_i;
    logic [16:0] exp_val;
    logic        accept;
    logic        accept_valid;
    logic        seq_err;

    modport master (
        output exp_init, exp_run, exp_fin, exp_recip, exp_x, exp_neg, rand_i,
        input  exp_val, accept, accept_valid, seq_err
    );

    modport slave (
        input  exp_init, exp_run, exp_fin, exp_recip, exp_x, exp_neg, rand_i,
        output exp_val, accept, accept_valid, seq_err
    );
endinterface
`default_nettype wire

// File: rtl/metropolis_exp.sv
`default_nettype none
// ============================================================================
//  Module      : metropolis_exp
//  Description : Metropolis acceptance test. Evaluates exp(-a) with a 15-term
//                Horner Taylor series stepped by the node controller, then
//                compares it against a uniform random value.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous active-high reset
//                bus    - metropolis_exp_if.slave (sequence in, decision out)
//  Parameters  : LFSR_SEED - non-zero LFSR reset seed (LFSR build only)
//  Build macro : METROPOLIS_LFSR_EN - when defined, an internal 16-bit Galois
//                LFSR (taps 0xB400) replaces rand_i as the random source.
//  Revision    : 1.0  initial release
// ============================================================================
module metropolis_exp #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    metropolis_exp_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [31:0] c_ONE_Y  = 32'sh0001_0000;
    localparam logic        [16:0] c_ONE_EV = 17'h10000;

    state_t             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic signed [31:0] y_q, y_d;
    logic [14:0]        x_q, x_d;
    logic               neg_q, neg_d;
    logic [16:0]        exp_val_q, exp_val_d;
    logic               accept_q, accept_d;
    logic               accept_valid_q, accept_valid_d;
    logic               seq_err_q, seq_err_d;

    logic [31:0]        w_tx_prod;
    logic [16:0]        w_t;
    logic signed [49:0] w_p_full;
    logic signed [49:0] w_p;
    logic signed [49:0] w_y_wide;
    logic signed [31:0] w_y_next;
    logic [16:0]        w_clamped;
    logic [15:0]        w_rand;

    // One Horner step: t = x/n (Q.12), p = t*y (Q.16), y' = 1 - p.
    assign w_tx_prod = {17'd0, x_q} * {15'd0, bus.exp_recip};
    assign w_t       = 17'(w_tx_prod >> 15);
    assign w_p_full  = $signed({33'd0, w_t}) * $signed({{18{y_q[31]}}, y_q});
    assign w_p       = w_p_full >>> 12;
    assign w_y_wide  = 50'sd65536 - w_p;

    always_comb begin
        w_y_next = w_y_wide[31:0];
        if (w_y_wide > 50'sd2147483647) begin
            w_y_next = 32'sh7FFF_FFFF;
        end else if (w_y_wide < -50'sd2147483648) begin
            w_y_next = 32'sh8000_0000;
        end
    end

    // Series result limited to the representable probability range [0, 1.0].
    always_comb begin
        w_clamped = w_y_next[16:0];
        if (w_y_next[31]) begin
            w_clamped = 17'd0;
        end else if (w_y_next > c_ONE_Y) begin
            w_clamped = c_ONE_EV;
        end
    end

`ifdef METROPOLIS_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign w_rand = lfsr_q;

    // Advance once per decision, after the current value has been used.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept_valid_d) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign w_rand = bus.rand_i;
`endif

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        y_d            = y_q;
        x_d            = x_q;
        neg_d          = neg_q;
        exp_val_d      = exp_val_q;
        accept_d       = accept_q;
        accept_valid_d = 1'b0;
        seq_err_d      = 1'b0;

        if (bus.exp_init) begin
            // A start always wins; anything but a clean start from IDLE is flagged.
            x_d       = bus.exp_x;
            neg_d     = bus.exp_neg;
            y_d       = c_ONE_Y;
            step_d    = 4'd15;
            state_d   = S_ITER;
            seq_err_d = (state_q != S_IDLE) || bus.exp_fin;
        end else if (bus.exp_fin) begin
            accept_valid_d = 1'b1;
            state_d        = S_IDLE;
            if (state_q == S_DONE) begin
                accept_d = neg_q | ({1'b0, w_rand} < exp_val_q);
            end else begin
                // No valid series result: only the unconditional case accepts.
                accept_d  = neg_q;
                seq_err_d = 1'b1;
            end
        end else if ((state_q == S_ITER) && bus.exp_run) begin
            y_d    = w_y_next;
            step_d = step_q - 4'd1;
            if (step_q == 4'd1) begin
                state_d   = S_DONE;
                exp_val_d = w_clamped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            step_q         <= 4'd0;
            y_q            <= 32'sd0;
            x_q            <= 15'd0;
            neg_q          <= 1'b0;
            exp_val_q      <= 17'd0;
            accept_q       <= 1'b0;
            accept_valid_q <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            y_q            <= y_d;
            x_q            <= x_d;
            neg_q          <= neg_d;
            exp_val_q      <= exp_val_d;
            accept_q       <= accept_d;
            accept_valid_q <= accept_valid_d;
            seq_err_q      <= seq_err_d;
        end
    end

    assign bus.exp_val      = exp_val_q;
    assign bus.accept       = accept_q;
    assign bus.accept_valid = accept_valid_q;
    assign bus.seq_err      = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_metropolis_exp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_metropolis_exp
//  Description : Directed self-checking bench for metropolis_exp. Expected
//                series values come from an integer model of the Horner
//                recurrence; decisions from the acceptance rule.
//  Build macro : METROPOLIS_LFSR_EN - bench tracks the internal LFSR sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_metropolis_exp;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [15:0] m_lfsr;

    metropolis_exp_if bus_if ();

    metropolis_exp #(.LFSR_SEED(16'hACE1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Q2.15 reciprocal 1/n, rounded.
    function automatic logic [16:0] rcp(input int n);
        return 17'((32768 + n / 2) / n);
    endfunction

    function automatic logic [16:0] model_exp(input logic [14:0] x);
        longint y, t, p;
        logic [16:0] r;
        y = 65536;
        for (int n = 15; n >= 1; n--) begin
            t = (longint'(x) * longint'(rcp(n))) >> 15;
            p = (t * y) >>> 12;
            y = 65536 - p;
            if (y > 64'sd2147483647)  y = 64'sd2147483647;
            if (y < -64'sd2147483648) y = -64'sd2147483648;
        end
        if (y < 0)          r = 17'd0;
        else if (y > 65536) r = 17'h10000;
        else                r = y[16:0];
        return r;
    endfunction

    // Random value consumed by a decision; advances the LFSR model when enabled.
    function automatic logic [15:0] next_rand(input logic [15:0] rnd);
        logic [15:0] r;
`ifdef METROPOLIS_LFSR_EN
        r      = m_lfsr;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`else
        r = rnd;
`endif
        return r;
    endfunction

    // Standard sequence: init at T, steps T+1..T+15, fin at T+18.
    task automatic run_eval(input string tag, input logic [14:0] x, input logic neg,
                            input logic [15:0] rnd, input logic init_err, input logic with_fin);
        logic [16:0] ev;
        logic [15:0] r;
        ev = model_exp(x);
        bus_if.exp_x    = x;
        bus_if.exp_neg  = neg;
        bus_if.exp_init = 1'b1;
        bus_if.exp_fin  = with_fin;
        tick();
        bus_if.exp_init = 1'b0;
        bus_if.exp_fin  = 1'b0;
        check_eq({tag, "_init_seqerr"}, 32'(bus_if.seq_err), 32'(init_err));
        if (with_fin) check_eq({tag, "_init_fin_noav"}, 32'(bus_if.accept_valid), 32'd0);
        for (int n = 15; n >= 1; n--) begin
            bus_if.exp_run   = 1'b1;
            bus_if.exp_recip = rcp(n);
            bus_if.rand_i    = 16'($urandom);
            tick();
        end
        bus_if.exp_run   = 1'b0;
        bus_if.exp_recip = 17'd0;
        check_eq({tag, "_val"}, 32'(bus_if.exp_val), 32'(ev));
        tick();
        tick();
        bus_if.rand_i  = rnd;
        bus_if.exp_fin = 1'b1;
        r = next_rand(rnd);
        tick();
        bus_if.exp_fin = 1'b0;
        check_eq({tag, "_av"}, 32'(bus_if.accept_valid), 32'd1);
        check_eq({tag, "_acc"}, 32'(bus_if.accept), 32'(neg | ({1'b0, r} < ev)));
        check_eq({tag, "_seqerr"}, 32'(bus_if.seq_err), 32'd0);
        tick();
        check_eq({tag, "_av_drop"}, 32'(bus_if.accept_valid), 32'd0);
    endtask

    initial begin
        logic [16:0] ev;
        n_checks = 0;
        n_errors = 0;
        m_lfsr   = 16'hACE1;
        reset    = 1'b1;
        bus_if.exp_init = 1'b0; bus_if.exp_run = 1'b0; bus_if.exp_fin = 1'b0;
        bus_if.exp_recip = 17'd0; bus_if.exp_x = 15'd0; bus_if.exp_neg = 1'b0;
        bus_if.rand_i = 16'd0;
        tick(); tick();
        check_eq("rst_val", 32'(bus_if.exp_val), 32'd0);
        check_eq("rst_acc", 32'(bus_if.accept), 32'd0);
        check_eq("rst_av",  32'(bus_if.accept_valid), 32'd0);
        check_eq("rst_err", 32'(bus_if.seq_err), 32'd0);
        reset = 1'b0;
        tick();

        // exp(0) = 1.0 always accepts.
        run_eval("a0", 15'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        check_eq("a0_one", 32'(bus_if.exp_val), 32'h10000);

        // exp(-1) ~ 0x5E2D.
        run_eval("a1_lo", 15'h1000, 1'b0, 16'h5000, 1'b0, 1'b0);
        ev = bus_if.exp_val;
        check_eq("a1_near", 32'((ev >= 17'h05E25) && (ev <= 17'h05E35)), 32'd1);
        run_eval("a1_hi", 15'h1000, 1'b0, 16'h6000, 1'b0, 1'b0);

        // a ~ 8: tiny result, must not wrap to a large value.
        run_eval("a8", 15'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("a8_range", 32'(bus_if.exp_val <= 17'd40), 32'd1);
        run_eval("a8_neg", 15'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // exp_fin at T+10, mid-ITER.
        bus_if.exp_x = 15'h1000; bus_if.exp_neg = 1'b0; bus_if.exp_init = 1'b1;
        tick();
        bus_if.exp_init = 1'b0;
        for (int n = 15; n >= 7; n--) begin
            bus_if.exp_run = 1'b1; bus_if.exp_recip = rcp(n); tick();
        end
        bus_if.exp_recip = rcp(6);
        bus_if.exp_fin   = 1'b1;
        void'(next_rand(16'd0));
        tick();
        bus_if.exp_fin = 1'b0; bus_if.exp_run = 1'b0;
        check_eq("midfin_av",   32'(bus_if.accept_valid), 32'd1);
        check_eq("midfin_err",  32'(bus_if.seq_err), 32'd1);
        check_eq("midfin_acc",  32'(bus_if.accept), 32'd0);
        check_eq("midfin_hold", 32'(bus_if.exp_val), 32'(model_exp(15'h7FFF)));
        tick();
        check_eq("midfin_err_drop", 32'(bus_if.seq_err), 32'd0);
        // A further exp_fin must see IDLE: flagged, not a real decision.
        bus_if.exp_fin = 1'b1;
        void'(next_rand(16'd0));
        tick();
        bus_if.exp_fin = 1'b0;
        check_eq("idlefin_err", 32'(bus_if.seq_err), 32'd1);
        check_eq("idlefin_av",  32'(bus_if.accept_valid), 32'd1);
        tick();

        // Restart at T+5: series must restart from 1/15 on the new operand.
        bus_if.exp_x = 15'h7FFF; bus_if.exp_neg = 1'b0; bus_if.exp_init = 1'b1;
        tick();
        bus_if.exp_init = 1'b0;
        for (int n = 15; n >= 12; n--) begin
            bus_if.exp_run = 1'b1; bus_if.exp_recip = rcp(n); tick();
        end
        bus_if.exp_run = 1'b0;
        run_eval("restart", 15'h1000, 1'b0, 16'h5000, 1'b1, 1'b0);

        // exp_init together with exp_fin: init wins, no decision.
        run_eval("initfin", 15'h0800, 1'b0, 16'h9000, 1'b1, 1'b1);

        // Reset at T+7 aborts the evaluation.
        bus_if.exp_x = 15'h1000; bus_if.exp_init = 1'b1;
        tick();
        bus_if.exp_init = 1'b0;
        for (int n = 15; n >= 10; n--) begin
            bus_if.exp_run = 1'b1; bus_if.exp_recip = rcp(n); tick();
        end
        bus_if.exp_run = 1'b0;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        check_eq("rst7_val", 32'(bus_if.exp_val), 32'd0);
        check_eq("rst7_acc", 32'(bus_if.accept), 32'd0);
        check_eq("rst7_av",  32'(bus_if.accept_valid), 32'd0);
        check_eq("rst7_err", 32'(bus_if.seq_err), 32'd0);
        begin
            int av_seen;
            av_seen = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (bus_if.accept_valid) av_seen++;
            end
            check_eq("rst7_no_av", 32'(av_seen), 32'd0);
        end

        // Five evaluations at a = 1.0 with varying random inputs.
        run_eval("seq0", 15'h1000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_eval("seq1", 15'h1000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_eval("seq2", 15'h1000, 1'b0, 16'h5E00, 1'b0, 1'b0);
        run_eval("seq3", 15'h1000, 1'b0, 16'h5E40, 1'b0, 1'b0);
        run_eval("seq4", 15'h1000, 1'b0, 16'h1234, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
